// File: rtl/mdu_ctrl_pkg.sv
// Shared order codes and local types for the multiply/divide controller.
package mdu_ctrl_pkg;

    localparam logic [6:0] ORD_NOP   = 7'h00;
    localparam logic [6:0] ORD_MULT  = 7'h20;
    localparam logic [6:0] ORD_MULTU = 7'h21;
    localparam logic [6:0] ORD_DIV   = 7'h22;
    localparam logic [6:0] ORD_DIVU  = 7'h23;
    localparam logic [6:0] ORD_MFHI  = 7'h24;
    localparam logic [6:0] ORD_MFLO  = 7'h25;
    localparam logic [6:0] ORD_MTHI  = 7'h26;
    localparam logic [6:0] ORD_MTLO  = 7'h27;

    typedef enum logic {ST_IDLE, ST_BUSY} mdu_state_e;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

    function automatic logic is_md_start(input logic [6:0] o);
        return (o == ORD_MULT) || (o == ORD_MULTU) || (o == ORD_DIV) || (o == ORD_DIVU);
    endfunction

    function automatic logic is_md_class(input logic [6:0] o);
        return is_md_start(o) || (o == ORD_MFHI) || (o == ORD_MFLO) ||
               (o == ORD_MTHI) || (o == ORD_MTLO);
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational result generator: {hi, lo} for the issuing mult/div order.
module mdu_calc
    import mdu_ctrl_pkg::*;
(
    input  logic [6:0]  order,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output hilo_t       res
);

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic signed [31:0] quo_s, rem_s;
    logic [31:0]        quo_u, rem_u;
    logic               div_ovf;

    assign prod_s  = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
    assign prod_u  = {32'h0, rs} * {32'h0, rt};
    assign quo_s   = $signed(rs) / $signed(rt);
    assign rem_s   = $signed(rs) % $signed(rt);
    assign quo_u   = rs / rt;
    assign rem_u   = rs % rt;
    // Most-negative / -1 overflows 32 bits; pin it to the wrapped quotient.
    assign div_ovf = (rs == 32'h8000_0000) && (rt == 32'hFFFF_FFFF);

    always_comb begin
        res = '{hi: hi, lo: lo};
        case (order)
            ORD_MULT:  res = prod_s;
            ORD_MULTU: res = prod_u;
            ORD_DIV: begin
                if (rt != 32'h0) begin
                    if (div_ovf) res = '{hi: 32'h0, lo: 32'h8000_0000};
                    else         res = '{hi: rem_s, lo: quo_s};
                end
            end
            ORD_DIVU: begin
                if (rt != 32'h0) res = '{hi: rem_u, lo: quo_u};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide controller: sequences fixed-latency ops, owns HI/LO,
// services mthi/mtlo/mfhi/mflo and raises the D-stage stall.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  e_order,
    input  logic [6:0]  d_order,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        req,
    output logic        start,
    output logic        busy,
    output logic        stall,
    output logic [31:0] md_out
);

    localparam int CMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    mdu_state_e    state, state_nxt;
    logic [CW-1:0] cnt;
    logic [31:0]   hi, lo;
    hilo_t         pend, calc_res;
    logic          is_mult;

    assign is_mult = (e_order == ORD_MULT) || (e_order == ORD_MULTU);

    mdu_calc u_calc (
        .order (e_order),
        .rs    (rs_val),
        .rt    (rt_val),
        .hi    (hi),
        .lo    (lo),
        .res   (calc_res)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_BUSY;
            ST_BUSY: if (cnt == CW'(1)) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state == ST_BUSY);
        start  = is_md_start(e_order) && !busy && !req;
        stall  = is_md_class(d_order) && (start || busy);
        md_out = 32'h0;
        if (e_order == ORD_MFHI)      md_out = hi;
        else if (e_order == ORD_MFLO) md_out = lo;
    end

    // Result is captured at issue; the busy window only models latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            hi   <= 32'h0;
            lo   <= 32'h0;
            pend <= '0;
        end else if (state == ST_IDLE) begin
            if (start) begin
                pend <= calc_res;
                cnt  <= is_mult ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            end else if (!req) begin
                if (e_order == ORD_MTHI) hi <= rs_val;
                if (e_order == ORD_MTLO) lo <= rs_val;
            end
        end else begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                hi <= pend.hi;
                lo <= pend.lo;
            end
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: expected HI/LO queued at issue, checked via mflo/mfhi.
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  e_order, d_order;
    logic [31:0] rs_val, rt_val;
    logic        req;
    logic        start, busy, stall;
    logic [31:0] md_out;

    int          checks = 0;
    int          failures = 0;
    logic [63:0] exp_q[$];
    logic [31:0] m_hi = 32'h0, m_lo = 32'h0;

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .e_order(e_order), .d_order(d_order),
        .rs_val(rs_val), .rt_val(rt_val), .req(req),
        .start(start), .busy(busy), .stall(stall), .md_out(md_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Two cycles: mflo then mfhi in E, compared against the next queued result.
    task automatic rd(input string tag);
        logic [63:0] e;
        e_order = ORD_MFLO;
        @(negedge clk);
        chk({tag, "_idle"}, {31'h0, busy}, 32'h0);
        chk({tag, "_nostall"}, {31'h0, stall}, 32'h0);
        if (exp_q.size() == 0) begin
            chk({tag, "_q_empty"}, 32'h1, 32'h0);
            e = {m_hi, m_lo};
        end else begin
            e = exp_q.pop_front();
        end
        chk({tag, "_lo"}, md_out, e[31:0]);
        nxt();
        d_order = ORD_NOP;
        e_order = ORD_MFHI;
        @(negedge clk);
        chk({tag, "_hi"}, md_out, e[63:32]);
        nxt();
        e_order = ORD_NOP;
        m_hi = e[63:32];
        m_lo = e[31:0];
    endtask

    task automatic run_op(input string tag, input logic [6:0] ord, input logic [31:0] a,
                          input logic [31:0] b, input int n, input logic [6:0] dord,
                          input int req_at, input logic [63:0] exp);
        logic [31:0] st_exp;
        st_exp = (dord != ORD_NOP) ? 32'h1 : 32'h0;
        e_order = ord; rs_val = a; rt_val = b; d_order = dord; req = 1'b0;
        @(negedge clk);
        chk({tag, "_start"}, {31'h0, start}, 32'h1);
        chk({tag, "_stall_t"}, {31'h0, stall}, st_exp);
        exp_q.push_back(exp);
        for (int i = 1; i <= n; i++) begin
            nxt();
            e_order = ORD_NOP;
            req = (i == req_at);
            @(negedge clk);
            chk({tag, "_busy"}, {31'h0, busy}, 32'h1);
            chk({tag, "_stall_b"}, {31'h0, stall}, st_exp);
        end
        nxt();
        req = 1'b0;
        rd(tag);
    endtask

    function automatic logic [63:0] mdl(input logic [6:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     r;
        sa = longint'($signed(a)); sb = longint'($signed(b));
        ua = {32'h0, a};           ub = {32'h0, b};
        r  = {m_hi, m_lo};
        case (o)
            ORD_MULT:  r = sa * sb;
            ORD_MULTU: r = ua * ub;
            ORD_DIV:   if (b != 0) begin
                           longint q, rm;
                           q = sa / sb; rm = sa % sb;
                           r = {rm[31:0], q[31:0]};
                       end
            ORD_DIVU:  if (b != 0) begin
                           longint unsigned q, rm;
                           q = ua / ub; rm = ua % ub;
                           r = {rm[31:0], q[31:0]};
                       end
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        reset = 1'b1; req = 1'b0;
        e_order = ORD_NOP; d_order = ORD_NOP; rs_val = 32'h0; rt_val = 32'h0;
        nxt(); nxt();
        reset = 1'b0;
        d_order = ORD_MFHI;
        @(negedge clk);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_start", {31'h0, start}, 32'h0);
        chk("rst_stall", {31'h0, stall}, 32'h0);
        nxt();
        exp_q.push_back(64'h0);
        rd("rst");

        run_op("mult", ORD_MULT, 32'hFFFF_FFFE, 32'd3, 5, ORD_NOP, 0,
               64'hFFFF_FFFF_FFFF_FFFA);
        run_op("divu", ORD_DIVU, 32'd100, 32'd7, 10, ORD_MFLO, 0, {32'd2, 32'd14});
        run_op("div_neg", ORD_DIV, 32'hFFFF_FFF9, 32'd2, 10, ORD_NOP, 0,
               64'hFFFF_FFFF_FFFF_FFFD);

        e_order = ORD_MTHI; rs_val = 32'h11; nxt();
        e_order = ORD_MTLO; rs_val = 32'h22; nxt();
        run_op("div0", ORD_DIV, 32'd9, 32'd0, 10, ORD_NOP, 0, {32'h11, 32'h22});

        e_order = ORD_MULTU; rs_val = 32'd5; rt_val = 32'd6; req = 1'b1;
        @(negedge clk);
        chk("req_start", {31'h0, start}, 32'h0);
        nxt();
        e_order = ORD_NOP; req = 1'b0;
        @(negedge clk);
        chk("req_busy", {31'h0, busy}, 32'h0);
        e_order = ORD_MTHI; rs_val = 32'hABCD; req = 1'b1; nxt();
        req = 1'b0;
        exp_q.push_back({m_hi, m_lo});
        rd("req_mthi");
        e_order = ORD_MTHI; rs_val = 32'hABCD; nxt();
        exp_q.push_back({32'hABCD, m_lo});
        rd("mthi");

        run_op("mult_req", ORD_MULT, 32'd7, 32'hFFFF_FFFD, 5, ORD_NOP, 2,
               64'hFFFF_FFFF_FFFF_FFEB);
        run_op("div_ovf", ORD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, ORD_NOP, 0,
               {32'h0, 32'h8000_0000});

        e_order = ORD_DIV; rs_val = 32'd50; rt_val = 32'd5;
        @(negedge clk);
        chk("rst_mid_start", {31'h0, start}, 32'h1);
        nxt(); e_order = ORD_NOP;
        nxt(); nxt();
        reset = 1'b1; d_order = ORD_MFLO;
        nxt();
        reset = 1'b0;
        exp_q.push_back(64'h0);
        rd("rst_mid");

        e_order = ORD_MTLO; rs_val = 32'd5; nxt();
        e_order = ORD_MULT; rs_val = 32'd2; rt_val = 32'd3;
        @(negedge clk);
        chk("b2b_start", {31'h0, start}, 32'h1);
        exp_q.push_back({32'h0, 32'd6});
        for (int i = 1; i <= 5; i++) begin
            nxt();
            e_order = (i == 1) ? ORD_MFLO : ORD_NOP;
            @(negedge clk);
            chk("b2b_busy", {31'h0, busy}, 32'h1);
            if (i == 1) chk("b2b_mtlo", md_out, 32'd5);
        end
        nxt();
        rd("b2b");

        for (int k = 0; k < 8; k++) begin
            logic [6:0]  o;
            logic [31:0] a, b;
            int          sel;
            sel = int'($urandom_range(0, 3));
            o = (sel == 0) ? ORD_MULT : (sel == 1) ? ORD_MULTU : (sel == 2) ? ORD_DIV : ORD_DIVU;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            run_op("rnd", o, a, b, (sel < 2) ? 5 : 10, ORD_NOP, 0, mdl(o, a, b));
        end

        chk("q_drained", exp_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
